// File: rtl/regfile_read_stage.sv
// Register file with two bypassed read ports and a per-register pending
// scoreboard that stalls reads of registers whose write-back is in flight.
module regfile_read_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_wen,
    input  logic [4:0]       wr_reg,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    output logic [WIDTH-1:0] rs1_data,
    output logic [WIDTH-1:0] rs2_data,
    output logic             rd_valid,
    input  logic             issue_valid,
    input  logic             issue_wen,
    input  logic [4:0]       issue_rd,
    output logic             stall,
    output logic [31:0]      pending
);

    logic [WIDTH-1:0] regs_q [1:31];
    logic [WIDTH-1:0] regs_d [1:31];
    logic [31:0]      pending_q, pending_d;
    logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic             rd_valid_q, rd_valid_d;

    logic             wr_hit1, wr_hit2;
    logic             haz1, haz2;
    logic [WIDTH-1:0] byp1, byp2;
    logic             accept;

    always_comb begin
        wr_hit1 = reg_wen && (wr_reg == rs1) && (rs1 != 5'd0);
        wr_hit2 = reg_wen && (wr_reg == rs2) && (rs2 != 5'd0);

        byp1 = '0;
        if (wr_hit1)
            byp1 = wr_data;
        else if (rs1 != 5'd0)
            byp1 = regs_q[rs1];

        byp2 = '0;
        if (wr_hit2)
            byp2 = wr_data;
        else if (rs2 != 5'd0)
            byp2 = regs_q[rs2];

        // A write-back landing this cycle resolves the hazard via the bypass
        haz1 = (rs1 != 5'd0) && pending_q[rs1] && !wr_hit1;
        haz2 = (rs2 != 5'd0) && pending_q[rs2] && !wr_hit2;

        stall  = rd_en && (haz1 || haz2);
        accept = rd_en && !stall;
    end

    always_comb begin
        regs_d = regs_q;
        if (reg_wen && wr_reg != 5'd0)
            regs_d[wr_reg] = wr_data;

        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        rd_valid_d = accept;
        if (accept) begin
            rs1_data_d = byp1;
            rs2_data_d = byp2;
        end

        // Set beats clear: the newer issue owns the register
        pending_d = pending_q;
        for (int i = 1; i < 32; i++) begin
            if (issue_valid && issue_wen && issue_rd == 5'(i))
                pending_d[i] = 1'b1;
            else if (reg_wen && wr_reg == 5'(i))
                pending_d[i] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q     <= '{default: '0};
            pending_q  <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            pending_q  <= pending_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rs1_data = rs1_data_q;
    assign rs2_data = rs2_data_q;
    assign rd_valid = rd_valid_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_regfile_read_stage.sv
// Vector table plus read-result scoreboard for regfile_read_stage.
module tb_regfile_read_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wen;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rs1, rs2;
    logic [31:0] rs1_data, rs2_data;
    logic        rd_valid;
    logic        issue_valid, issue_wen;
    logic [4:0]  issue_rd;
    logic        stall;
    logic [31:0] pending;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_read_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .reg_wen(reg_wen), .wr_reg(wr_reg), .wr_data(wr_data),
        .rd_en(rd_en), .rs1(rs1), .rs2(rs2),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_valid(rd_valid),
        .issue_valid(issue_valid), .issue_wen(issue_wen),
        .issue_rd(issue_rd), .stall(stall), .pending(pending)
    );

    typedef struct {
        bit          rst;
        bit          wen;
        logic [4:0]  wr;
        logic [31:0] wd;
        bit          rd;
        logic [4:0]  r1, r2;
        bit          iv, iw;
        logic [4:0]  ird;
        bit          e_stall;
        logic [31:0] e_pend;
        logic [31:0] e1, e2;
    } vec_t;

    typedef struct {
        logic [31:0] a, b;
    } exp_t;

    vec_t vt[$];
    exp_t sbq[$];

    function automatic vec_t mk(
        bit r, bit wen, logic [4:0] wr, logic [31:0] wd,
        bit rd, logic [4:0] r1, logic [4:0] r2,
        bit iv, bit iw, logic [4:0] ird,
        bit est, logic [31:0] ep, logic [31:0] e1, logic [31:0] e2);
        vec_t v;
        v.rst = r; v.wen = wen; v.wr = wr; v.wd = wd;
        v.rd = rd; v.r1 = r1; v.r2 = r2;
        v.iv = iv; v.iw = iw; v.ird = ird;
        v.e_stall = est; v.e_pend = ep; v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        rst = v.rst; reg_wen = v.wen; wr_reg = v.wr; wr_data = v.wd;
        rd_en = v.rd; rs1 = v.r1; rs2 = v.r2;
        issue_valid = v.iv; issue_wen = v.iw; issue_rd = v.ird;
    endtask

    localparam logic [31:0] P3 = 32'h1 << 3;
    localparam logic [31:0] P4 = 32'h1 << 4;
    localparam logic [31:0] P9 = 32'h1 << 9;

    initial begin
        exp_t e;
        string nm;
        vt.push_back(mk(1,0,0,0, 0,0,0, 0,0,0, 0,0, 0,0));
        vt.push_back(mk(1,1,5,32'h1111, 1,1,2, 1,1,6, 0,0, 0,0));
        vt.push_back(mk(0,1,5,32'hDEADBEEF, 0,0,0, 0,0,0, 0,0, 0,0));
        vt.push_back(mk(0,0,0,0, 1,5,0, 0,0,0, 0,0, 32'hDEADBEEF,0));
        vt.push_back(mk(0,1,0,32'h12345678, 0,0,0, 1,1,0, 0,0, 0,0));
        vt.push_back(mk(0,0,0,0, 1,0,5, 0,0,0, 0,0, 0,32'hDEADBEEF));
        vt.push_back(mk(0,1,7,32'hA5A5A5A5, 1,7,7, 0,0,0, 0,0,
                        32'hA5A5A5A5,32'hA5A5A5A5));
        vt.push_back(mk(0,0,0,0, 0,0,0, 1,1,3, 0,P3, 0,0));
        vt.push_back(mk(0,0,0,0, 1,0,3, 0,0,0, 1,P3, 0,0));
        vt.push_back(mk(0,0,0,0, 1,0,3, 0,0,0, 1,P3, 0,0));
        vt.push_back(mk(0,1,3,32'h55, 1,0,3, 0,0,0, 0,0, 0,32'h55));
        vt.push_back(mk(0,1,9,32'h99, 0,0,0, 1,1,9, 0,P9, 0,0));
        vt.push_back(mk(0,0,0,0, 1,9,0, 0,0,0, 1,P9, 0,0));
        vt.push_back(mk(0,1,9,32'h1234, 1,9,7, 0,0,0, 0,0,
                        32'h1234,32'hA5A5A5A5));
        vt.push_back(mk(0,0,0,0, 1,9,3, 0,0,0, 0,0, 32'h1234,32'h55));
        vt.push_back(mk(0,0,0,0, 0,0,0, 1,0,4, 0,0, 0,0));
        vt.push_back(mk(0,0,0,0, 0,0,0, 0,1,4, 0,0, 0,0));
        vt.push_back(mk(0,0,0,0, 0,0,0, 1,1,4, 0,P4, 0,0));
        vt.push_back(mk(0,0,0,0, 1,3,0, 1,1,4, 0,P4, 32'h55,0));

        @(negedge clk);
        foreach (vt[k]) begin
            drive(vt[k]);
            #1;
            $sformat(nm, "stall[%0d]", k);
            chk(nm, {31'd0, stall}, {31'd0, vt[k].e_stall});
            if (vt[k].rd && !vt[k].e_stall && !vt[k].rst) begin
                e.a = vt[k].e1;
                e.b = vt[k].e2;
                sbq.push_back(e);
            end
            @(posedge clk);
            #1;
            $sformat(nm, "pending[%0d]", k);
            chk(nm, pending, vt[k].e_pend);
            $sformat(nm, "rd_valid[%0d]", k);
            chk(nm, {31'd0, rd_valid}, {31'd0, sbq.size() != 0});
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                $sformat(nm, "rs1_data[%0d]", k);
                chk(nm, rs1_data, e.a);
                $sformat(nm, "rs2_data[%0d]", k);
                chk(nm, rs2_data, e.b);
            end else if (vt[k].rst) begin
                $sformat(nm, "rst_rs1[%0d]", k);
                chk(nm, rs1_data, 32'h0);
                $sformat(nm, "rst_rs2[%0d]", k);
                chk(nm, rs2_data, 32'h0);
            end
        end

        // Reset while a read of x4 is stalled; reset also beats a write
        drive(mk(0,0,0,0, 1,4,0, 0,0,0, 0,0, 0,0));
        #1;
        chk("midstall_stall", {31'd0, stall}, 32'd1);
        @(posedge clk);
        #1;
        chk("midstall_hold_valid", {31'd0, rd_valid}, 32'd0);
        chk("midstall_hold_rs1", rs1_data, 32'h55);
        drive(mk(1,1,10,32'hCAFE, 1,4,0, 1,1,12, 0,0, 0,0));
        @(posedge clk);
        #1;
        rst = 1'b0; reg_wen = 1'b0; issue_valid = 1'b0;
        #1;
        chk("rst_pending", pending, 32'h0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rs1", rs1_data, 32'h0);
        chk("rst_valid", {31'd0, rd_valid}, 32'd0);

        // Array contents cleared by reset, including the overridden write
        rs1 = 5'd5; rs2 = 5'd10;
        @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, rd_valid}, 32'd1);
        chk("post_rst_r5", rs1_data, 32'h0);
        chk("post_rst_r10", rs2_data, 32'h0);
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        chk("idle_valid", {31'd0, rd_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_read_stage.md
# regfile_read_stage

Register file and operand-read stage that consumes the write-back stage's output bus (`reg_wen`, `wr_reg`, `alu_result`) and supplies registered source operands to the execute stage. It holds 32 general-purpose registers (x0 hardwired to zero) and provides two read ports with same-cycle write-to-read bypass. A per-register pending scoreboard lets the issue logic stall reads of registers whose write-back is still in flight. It sits between decode and execute, closing the loop from write-back.

## Interface
- `WIDTH`, 32, data width of each register and of the operand outputs.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `reg_wen`  in  1  write enable from the write-back stage.
- `wr_reg`  in  5  write-back destination index.
- `wr_data`  in  WIDTH  write-back data (write-back `alu_result_out`).
- `rd_en`  in  1  operand read request from decode.
- `rs1`, `rs2`  in  5 each  source register indices.
- `rs1_data`, `rs2_data`  out  WIDTH each  registered operands.
- `rd_valid`  out  1  registered; operands captured this cycle are valid.
- `issue_valid`  in  1  an instruction is issued to execute this cycle.
- `issue_wen`  in  1  the issued instruction writes a register.
- `issue_rd`  in  5  destination of the issued instruction.
- `stall`  out  1  combinational; the requested read must wait.
- `pending`  out  32  registered scoreboard bit vector (debug/verification).

## Operation
- **Storage:** `regs[1..31]` each WIDTH bits. `regs[0]` does not exist; every read of index 0 returns 0.
- **Write:** on a rising edge with `reg_wen=1` and `wr_reg!=0`, `regs[wr_reg] <= wr_data`. A write to index 0 is discarded.
- **Bypass:** for each port, if `reg_wen=1`, `wr_reg==rsN` and `rsN!=0`, the captured value is `wr_data`. Otherwise it is `regs[rsN]`.
- **Stall:**
  - `hazN = pending[rsN] && !(reg_wen && wr_reg==rsN)` for `rsN!=0`; `hazN = 0` for `rsN==0`.
  - `stall = rd_en && (haz1 || haz2)`.
- **Capture:** on a rising edge with `rd_en && !stall`, `rs1_data`/`rs2_data` load their bypassed values and `rd_valid <= 1`. Otherwise the operand outputs hold and `rd_valid <= 0`.
- **Scoreboard:** `pending[0]` is always 0. For each index i≠0, on every rising edge:
  - Set if `issue_valid && issue_wen && issue_rd==i`.
  - Else clear if `reg_wen && wr_reg==i`.
  - Else hold.
  - When set and clear hit the same index in the same cycle, set wins: the newer instruction owns the register.
- **In-order assumption:** the pipeline completes writes in order, so one pending bit per register is sufficient. A second issue to an already-pending rd leaves the bit set.

## Timing
- **Reset:** on a rising edge with `rst=1`, all `regs` clear to 0, `pending` clears to 0, `rs1_data`/`rs2_data` clear to 0, and `rd_valid` clears to 0. `stall` is then 0 because `pending` is 0. Reset overrides any write, issue or read in the same cycle. Reset asserted mid-stall drops the stall on the next cycle.
- **Read latency:** 1 cycle from an accepted `rd_en` to valid operands and `rd_valid=1`.
- **Write visibility:**
  - A write at edge N is visible through the array to reads captured at edge N+1 onward.
  - A read captured at edge N sees same-edge data via the bypass.
- **Stall path:** `stall` is combinational from `rd_en`, `rs1`, `rs2`, `pending`, `reg_wen` and `wr_reg`. It has no dependency on `issue_*`.
- **Stall clearing:** a stalled read stays stalled until the write-back for that register arrives. In that write-back cycle `stall` drops, the read completes with the bypassed data, and the pending bit clears at the same edge.
- **Issue to pending:** issuing at edge N makes `pending` visible from cycle N+1.

## Test plan
- **Reset, write, read back:**
  - Assert `rst` for 2 cycles. Write `wr_reg=5`, `wr_data=0xDEADBEEF`.
  - Next cycle, read `rs1=5`, `rs2=0`.
  - Required: one cycle later `rs1_data=0xDEADBEEF`, `rs2_data=0`, `rd_valid=1`.
- **x0 write discarded:**
  - Write `wr_reg=0`, `wr_data=0x12345678`, then read `rs1=0`.
  - Required: `rs1_data=0`; `pending[0]` stays 0 even after an issue with `issue_rd=0`.
- **Same-cycle bypass:**
  - Write `wr_reg=7`, `wr_data=0xA5A5A5A5` in the same cycle as reading `rs1=7`, `rs2=7`.
  - Required: both operands read `0xA5A5A5A5` after 1 cycle.
- **Scoreboard stall:**
  - Issue with `issue_rd=3`. Next cycle, read `rs2=3`.
  - Required: `stall=1` and `rd_valid=0` for 2 idle cycles.
  - Then write back `wr_reg=3`, `wr_data=0x55`. Required: `stall=0` that cycle, `rs2_data=0x55` next cycle, `pending[3]=0`.
- **Set-wins collision:**
  - In one cycle, issue `issue_rd=9` and write back `wr_reg=9`.
  - Required: `pending[9]=1` afterward, and a following read of `rs1=9` stalls.
- **Reset mid-stall:**
  - With `pending[4]=1` and a stalled read of `rs1=4`, assert `rst`.
  - Required: next cycle `pending=0`, `stall=0`, `rs1_data=0`, `rd_valid=0`.
